// File: rtl/operand_forward_ctrl_pkg.sv
// rtl/operand_forward_ctrl_pkg.sv - operand mux select codes and operand-kind encodings
package operand_forward_ctrl_pkg;

  localparam logic [2:0] SEL_REGFILE = 3'b000;
  localparam logic [2:0] SEL_FWD_D1  = 3'b001;
  localparam logic [2:0] SEL_FWD_D2  = 3'b010;
  localparam logic [2:0] SEL_FWD_D3  = 3'b011;
  localparam logic [2:0] SEL_IMM     = 3'b100;
  localparam logic [2:0] SEL_PC      = 3'b101;

  typedef enum logic [1:0] {
    OPSEL_REG  = 2'b00,
    OPSEL_IMM  = 2'b01,
    OPSEL_PC   = 2'b10,
    OPSEL_RSVD = 2'b11
  } opsel_e;

endpackage

// File: rtl/operand_forward_ctrl_if.sv
// rtl/operand_forward_ctrl_if.sv - issue-side and select-side signals of the forwarding control
interface operand_forward_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      flush;
  logic                      issue_valid;
  logic [REG_ADDR_WIDTH-1:0] issue_src;
  logic [1:0]                issue_opsel;
  logic [REG_ADDR_WIDTH-1:0] issue_dst;
  logic                      issue_wen;
  logic                      issue_load;
  logic                      stall;
  logic [2:0]                select;
  logic                      select_valid;

  modport master (
    output flush, issue_valid, issue_src, issue_opsel, issue_dst, issue_wen, issue_load,
    input  stall, select, select_valid
  );

  modport slave (
    input  flush, issue_valid, issue_src, issue_opsel, issue_dst, issue_wen, issue_load,
    output stall, select, select_valid
  );
endinterface

// File: rtl/operand_forward_ctrl_fwd_track_slot.sv
// rtl/operand_forward_ctrl_fwd_track_slot.sv - one in-flight destination slot with source match
module operand_forward_ctrl_fwd_track_slot #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ZERO_REG       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH+2:0] shift_in,
  input  logic [REG_ADDR_WIDTH-1:0] src,
  output logic [REG_ADDR_WIDTH+2:0] q,
  output logic                      match
);
  localparam int EW = REG_ADDR_WIDTH + 3;

  // entry layout: {valid, dst, wen, load}
  logic [EW-1:0] q_r;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_r <= '0;
    end else begin
      q_r <= shift_in;
    end
  end

  assign q     = q_r;
  assign match = q_r[EW-1] && q_r[1] && (q_r[EW-2:2] == src)
                 && (src != REG_ADDR_WIDTH'(ZERO_REG));
endmodule

// File: rtl/operand_forward_ctrl.sv
// rtl/operand_forward_ctrl.sv - operand mux select generation with EX/MEM/WB forwarding and load-use stall
module operand_forward_ctrl
  import operand_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ZERO_REG       = 0
) (
  input logic                 clk,
  input logic                 rst,
  operand_forward_ctrl_if.slave bus
);
  localparam int EW = REG_ADDR_WIDTH + 3;

  logic [EW-1:0] new_entry;
  logic [EW-1:0] d1_q;
  logic [EW-1:0] d2_q;
  logic [EW-1:0] tail_unused;
  logic          m1, m2, m3;
  logic          stall;
  logic          accept;
  logic [2:0]    sel_next;
  logic [2:0]    sel_r;
  logic          sel_valid_r;
  opsel_e        opsel;

  assign opsel  = opsel_e'(bus.issue_opsel);
  assign stall  = bus.issue_valid && (opsel == OPSEL_REG) && m1 && d1_q[0];
  assign accept = bus.issue_valid && !stall && !bus.flush;

  // a rejected or absent issue enters the pipeline as a bubble
  assign new_entry = accept ? {1'b1, bus.issue_dst, bus.issue_wen, bus.issue_load} : '0;

  operand_forward_ctrl_fwd_track_slot #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_d1 (
    .clk(clk), .rst(rst), .flush(bus.flush), .shift_in(new_entry),
    .src(bus.issue_src), .q(d1_q), .match(m1)
  );

  operand_forward_ctrl_fwd_track_slot #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_d2 (
    .clk(clk), .rst(rst), .flush(bus.flush), .shift_in(d1_q),
    .src(bus.issue_src), .q(d2_q), .match(m2)
  );

  operand_forward_ctrl_fwd_track_slot #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_d3 (
    .clk(clk), .rst(rst), .flush(bus.flush), .shift_in(d2_q),
    .src(bus.issue_src), .q(tail_unused), .match(m3)
  );

  always_comb begin
    sel_next = SEL_REGFILE;
    case (opsel)
      OPSEL_IMM:  sel_next = SEL_IMM;
      OPSEL_PC:   sel_next = SEL_PC;
      OPSEL_RSVD: sel_next = SEL_REGFILE;
      default: begin
        if (m1)      sel_next = SEL_FWD_D1;
        else if (m2) sel_next = SEL_FWD_D2;
        else if (m3) sel_next = SEL_FWD_D3;
        else         sel_next = SEL_REGFILE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r       <= SEL_REGFILE;
      sel_valid_r <= 1'b0;
    end else if (accept) begin
      sel_r       <= sel_next;
      sel_valid_r <= 1'b1;
    end else begin
      sel_valid_r <= 1'b0;
    end
  end

  assign bus.stall        = stall;
  assign bus.select       = sel_r;
  assign bus.select_valid = sel_valid_r;
endmodule

// File: tb/tb_operand_forward_ctrl.sv
// tb/tb_operand_forward_ctrl.sv - directed and randomized checks against a history-list model
module tb_operand_forward_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  operand_forward_ctrl_if #(.REG_ADDR_WIDTH(5)) bus ();

  operand_forward_ctrl #(.REG_ADDR_WIDTH(5), .ZERO_REG(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    bit v;
    int dst;
    bit wen;
    bit ld;
  } ent_t;

  ent_t     hist[$];   // hist[0] is the instruction issued one cycle ago
  logic [2:0] m_sel = 3'b000;
  logic       m_sv  = 1'b0;
  logic       obs_stall;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // youngest distance (1..3) whose writer targets src, 0 when none
  function automatic int dist_of(int src);
    for (int d = 0; d < hist.size(); d++)
      if (hist[d].v && hist[d].wen && hist[d].dst == src && src != 0) return d + 1;
    return 0;
  endfunction

  task automatic put(logic v, logic [4:0] src, logic [1:0] op, logic [4:0] dst,
                     logic wen, logic ld, logic fl);
    bus.issue_valid = v;
    bus.issue_src   = src;
    bus.issue_opsel = op;
    bus.issue_dst   = dst;
    bus.issue_wen   = wen;
    bus.issue_load  = ld;
    bus.flush       = fl;
  endtask

  task automatic cycle();
    int   d;
    logic e_stall;
    logic [2:0] e_sel;
    ent_t ne;
    #1;
    d = dist_of(int'(bus.issue_src));
    e_stall = bus.issue_valid && bus.issue_opsel == 2'd0 && d == 1 && hist[0].ld;
    case (bus.issue_opsel)
      2'd1:    e_sel = 3'd4;
      2'd2:    e_sel = 3'd5;
      2'd3:    e_sel = 3'd0;
      default: e_sel = 3'(d);
    endcase
    obs_stall = bus.stall;
    chk("stall", {31'd0, bus.stall}, {31'd0, e_stall});
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_sel = 3'd0;
      m_sv  = 1'b0;
    end else if (bus.flush) begin
      hist.delete();
      m_sv = 1'b0;
    end else begin
      ne = '{v: 1'b0, dst: 0, wen: 1'b0, ld: 1'b0};
      if (bus.issue_valid && !e_stall) begin
        ne = '{v: 1'b1, dst: int'(bus.issue_dst), wen: bus.issue_wen, ld: bus.issue_load};
        m_sel = e_sel;
        m_sv  = 1'b1;
      end else begin
        m_sv = 1'b0;
      end
      hist.push_front(ne);
      if (hist.size() > 3) void'(hist.pop_back());
    end
    #1;
    chk("select", {29'd0, bus.select}, {29'd0, m_sel});
    chk("select_valid", {31'd0, bus.select_valid}, {31'd0, m_sv});
  endtask

  initial begin
    put(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_select", {29'd0, bus.select}, 32'd0);
    chk("rst_select_valid", {31'd0, bus.select_valid}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;

    put(1, 0, 2'b01, 4, 0, 0, 0);
    cycle();
    chk("imm_sel", {29'd0, bus.select}, 32'd4);
    chk("imm_valid", {31'd0, bus.select_valid}, 32'd1);

    for (int gap = 0; gap < 4; gap++) begin
      put(1, 0, 2'b01, 5, 1, 0, 0);
      cycle();
      for (int k = 0; k < gap; k++) begin
        put(1, 1, 2'b00, 9, 1, 0, 0);
        cycle();
      end
      put(1, 5, 2'b00, 10, 1, 0, 0);
      cycle();
      chk($sformatf("gap%0d_sel", gap), {29'd0, bus.select}, (gap == 3) ? 32'd0 : 32'(gap + 1));
    end

    put(1, 0, 2'b01, 7, 1, 1, 0);
    cycle();
    put(1, 7, 2'b00, 11, 1, 0, 0);
    cycle();
    chk("lu_stall_on", {31'd0, obs_stall}, 32'd1);
    chk("lu_bubble", {31'd0, bus.select_valid}, 32'd0);
    cycle();
    chk("lu_stall_off", {31'd0, obs_stall}, 32'd0);
    chk("lu_sel", {29'd0, bus.select}, 32'd2);
    chk("lu_valid", {31'd0, bus.select_valid}, 32'd1);

    put(1, 0, 2'b01, 0, 1, 0, 0);
    cycle();
    put(1, 0, 2'b00, 12, 1, 0, 0);
    cycle();
    chk("r0_stall", {31'd0, obs_stall}, 32'd0);
    chk("r0_sel", {29'd0, bus.select}, 32'd0);

    put(1, 0, 2'b01, 3, 1, 0, 0);
    cycle();
    put(1, 1, 2'b00, 9, 1, 0, 0);
    cycle();
    put(1, 0, 2'b01, 3, 1, 0, 0);
    cycle();
    put(1, 3, 2'b00, 13, 1, 0, 0);
    cycle();
    chk("youngest_sel", {29'd0, bus.select}, 32'd1);

    put(1, 0, 2'b01, 6, 1, 0, 0);
    cycle();
    put(1, 6, 2'b00, 14, 1, 0, 1);
    cycle();
    chk("flush_valid", {31'd0, bus.select_valid}, 32'd0);
    put(1, 6, 2'b00, 14, 1, 0, 0);
    cycle();
    chk("flush_sel", {29'd0, bus.select}, 32'd0);

    put(1, 0, 2'b01, 8, 1, 1, 0);
    cycle();
    put(1, 8, 2'b00, 15, 1, 0, 0);
    rst = 1'b1;
    cycle();
    chk("rst_mid_stall", {31'd0, obs_stall}, 32'd1);
    rst = 1'b0;
    cycle();
    chk("rst_stall_drop", {31'd0, obs_stall}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      put(($urandom % 4) != 0, 5'($urandom % 4),
          (($urandom % 8) < 5) ? 2'b00 : 2'($urandom % 4),
          5'($urandom % 4), 1'($urandom % 2), ($urandom % 3) == 0,
          ($urandom % 16) == 0);
      rst = (($urandom % 50) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
